control_sequencer: RTL

Parametrised hardwired control unit that drives the bus-based datapath through the fetch/execute sequence T0..T5 for three-register ALU instructions.
It replaces hand-sequenced control strobes with an FSM, and adds a memory-ready handshake, run/single-step mode, illegal-opcode trapping and an instruction counter.

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/control_sequencer_if.sv | 58 +++++
 rtl/ir_decode.sv | 49 ++++
 rtl/control_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: FSM state encoding,
// supported ALU opcodes and instruction-register field layout.
//   Register fields sit directly below the opcode, MSB first:
//   opcode | Ra | Rb | Rc | unused low bits.
package ctrl_pkg;

    localparam int unsigned IR_W = 32;

    // Bit position of the opcode MSB.
    // Ra, Rb and Rc follow it downwards, each RSEL_W bits wide.
    localparam int unsigned IR_OPC_MSB = 31;

    localparam int unsigned OPC_ADD = 3;
    localparam int unsigned OPC_SUB = 4;
    localparam int unsigned OPC_AND = 5;
    localparam int unsigned OPC_OR  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5
    } state_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control sequencer bus.
//   inputs to the sequencer:
//     start, run, mem_ready
//     ir (datapath instruction register)
//   outputs from the sequencer:
//     bus-drive strobes:  pcout, zlowout, mdrout
//     load strobes:       marin, zin, pcin, mdrin, irin, yin
//     control strobes:    incpc, read
//     one-hot registers:  rin, rout
//     ALU and status:     alu_op, busy, done, illegal, instr_count
// Modports:
//   master - the sequencer, which drives the control strobes
//   slave  - the datapath side
interface control_sequencer_if
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG  = 16,
    parameter int unsigned OPC_W = 5,
    parameter int unsigned CNT_W = 16
) ();

    logic             start;
    logic             run;
    logic             mem_ready;
    logic [IR_W-1:0]  ir;

    logic             pcout;
    logic             zlowout;
    logic             mdrout;
    logic             marin;
    logic             zin;
    logic             pcin;
    logic             mdrin;
    logic             irin;
    logic             yin;
    logic             incpc;
    logic             read;
    logic [NREG-1:0]  rin;
    logic [NREG-1:0]  rout;
    logic [OPC_W-1:0] alu_op;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, run, mem_ready, ir,
        output pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin,
               incpc, read, rin, rout, alu_op, busy, done, illegal, instr_count
    );

    modport slave (
        output start, run, mem_ready, ir,
        input  pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin,
               incpc, read, rin, rout, alu_op, busy, done, illegal, instr_count
    );

endinterface

// File: rtl/ir_decode.sv
// Combinational IR decoder.
//   in : ir
//   out: ra_oh_c, rb_oh_c, rc_oh_c (one-hot register selects)
//        legal_c (opcode is a supported ALU operation)
//        alu_op_c (opcode when legal, else 0)
module ir_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG   = 16,
    parameter int unsigned RSEL_W = 4,
    parameter int unsigned OPC_W  = 5
) (
    input  logic [IR_W-1:0]  ir,
    output logic [NREG-1:0]  ra_oh_c,
    output logic [NREG-1:0]  rb_oh_c,
    output logic [NREG-1:0]  rc_oh_c,
    output logic             legal_c,
    output logic [OPC_W-1:0] alu_op_c
);

    localparam int unsigned OPC_LSB = IR_OPC_MSB + 1 - OPC_W;
    localparam int unsigned RA_LSB  = OPC_LSB - RSEL_W;
    localparam int unsigned RB_LSB  = RA_LSB - RSEL_W;
    localparam int unsigned RC_LSB  = RB_LSB - RSEL_W;

    logic [OPC_W-1:0]  opc;
    logic [RSEL_W-1:0] ra;
    logic [RSEL_W-1:0] rb;
    logic [RSEL_W-1:0] rc;
    logic              unused_ir_low;

    assign opc = ir[OPC_LSB +: OPC_W];
    assign ra  = ir[RA_LSB +: RSEL_W];
    assign rb  = ir[RB_LSB +: RSEL_W];
    assign rc  = ir[RC_LSB +: RSEL_W];

    // Low IR bits carry no control information for three-register ALU ops.
    assign unused_ir_low = ^ir[RC_LSB-1:0];

    assign ra_oh_c = NREG'(1) << ra;
    assign rb_oh_c = NREG'(1) << rb;
    assign rc_oh_c = NREG'(1) << rc;

    assign legal_c = (opc == OPC_W'(OPC_ADD)) || (opc == OPC_W'(OPC_SUB)) ||
                     (opc == OPC_W'(OPC_AND)) || (opc == OPC_W'(OPC_OR));

    assign alu_op_c = legal_c ? opc : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for three-register ALU instructions.
// Steps the datapath through T0..T5 and includes:
//   - memory-ready wait in T1
//   - run / single-step
//   - illegal-opcode trap in T3
//   - completed-instruction counter
// Ports:
//   Clock   - system clock
//   Reset_n - asynchronous active-low reset
//   bus     - control_sequencer_if.master (inputs, strobes, status)
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG   = 16,
    parameter int unsigned RSEL_W = 4,
    parameter int unsigned OPC_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    control_sequencer_if.master  bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;

    logic [NREG-1:0]  ra_oh;
    logic [NREG-1:0]  rb_oh;
    logic [NREG-1:0]  rc_oh;
    logic             legal;
    logic [OPC_W-1:0] dec_op;

    ir_decode #(
        .NREG   (NREG),
        .RSEL_W (RSEL_W),
        .OPC_W  (OPC_W)
    ) u_ir_decode (
        .ir       (bus.ir),
        .ra_oh_c  (ra_oh),
        .rb_oh_c  (rb_oh),
        .rc_oh_c  (rc_oh),
        .legal_c  (legal),
        .alu_op_c (dec_op)
    );

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completed-instruction counter; wraps naturally at 2**CNT_W
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else if (state_q == ST_T5) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.instr_count = count_q;

    // Next-state and strobe decode
    always_comb begin
        state_d     = state_q;
        bus.pcout   = 1'b0;
        bus.zlowout = 1'b0;
        bus.mdrout  = 1'b0;
        bus.marin   = 1'b0;
        bus.zin     = 1'b0;
        bus.pcin    = 1'b0;
        bus.mdrin   = 1'b0;
        bus.irin    = 1'b0;
        bus.yin     = 1'b0;
        bus.incpc   = 1'b0;
        bus.read    = 1'b0;
        bus.rin     = '0;
        bus.rout    = '0;
        bus.alu_op  = '0;
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        bus.busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_T0;
                end
            end
            ST_T0: begin
                bus.pcout = 1'b1;
                bus.marin = 1'b1;
                bus.incpc = 1'b1;
                bus.zin   = 1'b1;
                state_d   = ST_T1;
            end
            ST_T1: begin
                // Strobes repeat while memory stalls; reloading PC with Z is harmless
                bus.zlowout = 1'b1;
                bus.pcin    = 1'b1;
                bus.read    = 1'b1;
                bus.mdrin   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_T2;
                end
            end
            ST_T2: begin
                bus.mdrout = 1'b1;
                bus.irin   = 1'b1;
                state_d    = ST_T3;
            end
            ST_T3: begin
                if (legal) begin
                    bus.rout = rb_oh;
                    bus.yin  = 1'b1;
                    state_d  = ST_T4;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_T4: begin
                bus.rout   = rc_oh;
                bus.zin    = 1'b1;
                bus.alu_op = dec_op;
                state_d    = ST_T5;
            end
            ST_T5: begin
                bus.zlowout = 1'b1;
                bus.rin     = ra_oh;
                // Stop decision is made in this cycle, so Done follows Run here
                bus.done    = !bus.run;
                state_d     = bus.run ? ST_T0 : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
